sdram_bank_manager: RTL and testbench
=====================================

Name: sdram_bank_manager

Overview:
- Parametrised per-bank state and timing tracker for SDR SDRAM controllers; generalises the fixed 4-bank, single-chip timing set to NBANK banks with cycle counts derived from ns parameters and CLK_FREQ.
- Sits beside the controller command FSM. Observes every issued command, answers row-hit/miss queries, gates legal commands and schedules auto-refresh with postponement.

Parameters:
- NBANK, 4, bank count (power of 2, 2..8)
- RAW, 12, row address width
- CLK_FREQ, 100, clock frequency in MHz
- tRAS, 42, ns, ACT to PRE same bank
- tRC, 60, ns, ACT to ACT same bank
- tRCD, 18, ns, ACT to RD/WR same bank
- tRP, 18, ns, PRE to ACT same bank
- tRRD, 20, ns, ACT to ACT any bank
- tRFC, 60, ns, REF to any command
- tWR, 15, ns, last write data to PRE same bank
- cMRD, 2, cycles, MRS to any command
- tREF, 64, ms, refresh period
- MAX_POSTPONE, 8, maximum pending refreshes

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active high
- cmd_valid  in  1  command issued to SDRAM this cycle
- cmd_type  in  3  sdram_cmd_e: NOP, ACT, RD, WR, PRE, PREA, REF, MRS
- cmd_ba  in  $clog2(NBANK)  command bank
- cmd_row  in  RAW  row for ACT
- q_ba  in  $clog2(NBANK)  query bank
- q_row  in  RAW  query row
- q_status  out  2  0 closed, 1 hit, 2 conflict (combinational on registered state)
- q_act_ok  out  1  ACT to q_ba legal this cycle
- q_rw_ok  out  1  RD/WR to q_ba legal this cycle
- q_pre_ok  out  1  PRE to q_ba legal this cycle
- all_idle  out  1  every bank closed and PRE timers done (REF/MRS legal)
- ref_req  out  1  one or more refreshes pending
- ref_urgent  out  1  pending count equals MAX_POSTPONE
- ref_pending  out  $clog2(MAX_POSTPONE+1)  pending refresh count
- cmd_illegal  out  1  registered pulse: previous command violated timing (optional feature)

Behaviour:
- Cycle conversion: N = ceil(ns*CLK_FREQ/1000), minimum 1. tREFI = floor(tREF*1e6/2^RAW * CLK_FREQ/1000). Defaults give RCD 2, RAS 5, RC 6, RP 2, RRD 2, RFC 6, WR 2, REFI 1562.
- Timing semantics: for a constraint of N cycles after a command in cycle t, the gated command is legal in cycle t+N and later.
- Per-bank state is IDLE or ACTIVE. Each bank holds open_row and down-counters rcd, ras, rc, rp, wr. Globals: rrd, rfc, mrd.
- ACT: bank goes ACTIVE and open_row <= cmd_row; rcd, ras, rc and the global rrd are loaded.
- WR: the bank's wr counter is loaded. RD does not change state.
- PRE: the bank goes IDLE and rp is loaded. PREA does this for every bank.
- REF: rfc is loaded and ref_pending is decremented. MRS: mrd is loaded.
- q_act_ok = bank IDLE & rp==0 & rc==0 & rrd==0 & rfc==0 & mrd==0.
- q_rw_ok = bank ACTIVE & rcd==0.
- q_pre_ok = bank ACTIVE & ras==0 & wr==0. It is also high for an IDLE bank (PRE as NOP).
- q_status = closed if IDLE; hit if open_row==q_row; conflict otherwise.
- Refresh timer: counts tREFI-1 down to 0, then reloads and increments ref_pending, saturating at MAX_POSTPONE.
- Timer expiry in the same cycle as REF leaves ref_pending unchanged.
- REF while ref_pending==0 leaves the count at 0 (no underflow).
- Commands with cmd_valid low are ignored.
- Reset: all banks IDLE, open_row 0, all counters 0, refresh timer at tREFI-1, ref_pending 0.
- Output values in reset: q_status per q_ba (0), ok outputs high except as gated, all_idle 1, ref_req 0, ref_urgent 0, cmd_illegal 0.
- Reset mid-operation aborts all timers immediately.

Optional Feature:
- SDRAM_BANK_CHECK_EN defined: cmd_illegal pulses for one cycle after any of these:
  - ACT/RD/WR/PRE that would fail the matching ok check for cmd_ba
  - REF/MRS while all_idle is low
  - ACT to an ACTIVE bank
  - RD/WR to an IDLE bank
- Bank state still updates as commanded.
- Undefined: cmd_illegal is tied to 0 and the check logic is absent.

Decomposition:
- Package sdram_pkg holds:
  - sdram_cmd_e enum
  - q_status encoding constants
  - function ns2cyc(ns, freq) (ceil)
  - function refi_cyc(tref_ms, raw, freq) (floor)
- One sub-module, sdram_bank_timer, holds one bank's state, open_row and counters. It is instantiated NBANK times by generate.

Test Plan:
- Reset, then ACT bank1 row 0x123 at t0:
  - q_rw_ok(1) low t0+1, high t0+2
  - q_pre_ok(1) high at t0+5
  - q_status(1, row 0x123)=1; q_status(1, row 0x124)=2
- ACT bank0 at t0, query bank2: q_act_ok low at t0+1, high at t0+2 (tRRD). PRE bank0 at t0+5: q_act_ok(0) high at t0+7.
- WR bank3 at t0 after tRCD met: q_pre_ok(3) low at t0+1, high at t0+2.
- PREA then REF at t0:
  - all_idle low t0..t0+5, high t0+6
  - ref_pending decrements
- Idle for 1562*8 cycles: ref_pending reaches 8 and saturates; ref_urgent 1. REF issued on an expiry cycle leaves the count unchanged.
- With SDRAM_BANK_CHECK_EN: RD to an IDLE bank, or ACT 1 cycle after PRE → cmd_illegal pulses next cycle. Without the macro it stays 0.

Source files
------------

// File: rtl/sdram_bank_manager_pkg.sv
// Shared types, status encodings and timing-conversion helpers for the SDRAM bank manager.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6,
        CMD_MRS  = 3'd7
    } sdram_cmd_e;

    localparam logic [1:0] QS_CLOSED   = 2'd0;
    localparam logic [1:0] QS_HIT      = 2'd1;
    localparam logic [1:0] QS_CONFLICT = 2'd2;

    // Nanoseconds to clock cycles, rounded up, never below one cycle.
    function automatic int ns2cyc(input int ns, input int freq);
        int n;
        n = (ns * freq + 32'sd999) / 32'sd1000;
        return (n < 32'sd1) ? 32'sd1 : n;
    endfunction

    // Average refresh interval in cycles: tREF spread over 2^raw rows, rounded down.
    function automatic int refi_cyc(input int tref_ms, input int raw, input int freq);
        longint num;
        num = longint'(tref_ms) * 64'sd1000 * longint'(freq);
        return int'(num >>> raw);
    endfunction

endpackage

// File: rtl/sdram_bank_manager_bank_timer.sv
// One SDRAM bank: open/closed state, open row and the per-bank timing down-counters.
module sdram_bank_timer
    import sdram_pkg::*;
#(
    parameter int RAW   = 12,
    parameter int CW    = 5,
    parameter int L_RCD = 1,
    parameter int L_RAS = 4,
    parameter int L_RC  = 5,
    parameter int L_RP  = 1,
    parameter int L_WR  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_act,
    input  logic           i_wr,
    input  logic           i_pre,
    input  logic [RAW-1:0] i_row,
    output logic           o_active,
    output logic [RAW-1:0] o_open_row,
    output logic           o_act_ok,
    output logic           o_rw_ok,
    output logic           o_pre_ok,
    output logic           o_pre_done
);

    localparam logic [CW-1:0] ZERO = {CW{1'b0}};

    logic           r_active;
    logic [RAW-1:0] r_open_row;
    logic [CW-1:0]  r_rcd;
    logic [CW-1:0]  r_ras;
    logic [CW-1:0]  r_rc;
    logic [CW-1:0]  r_rp;
    logic [CW-1:0]  r_wr;

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        return (v == ZERO) ? v : v - CW'(1);
    endfunction

    // Bank open/closed state and the row latched by ACT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active   <= 1'b0;
            r_open_row <= {RAW{1'b0}};
        end else if (i_act) begin
            r_active   <= 1'b1;
            r_open_row <= i_row;
        end else if (i_pre) begin
            r_active   <= 1'b0;
            r_open_row <= r_open_row;
        end else begin
            r_active   <= r_active;
            r_open_row <= r_open_row;
        end
    end

    // Timing counters: loaded with N-1 so the gated command becomes legal N cycles later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rcd <= ZERO;
            r_ras <= ZERO;
            r_rc  <= ZERO;
            r_rp  <= ZERO;
            r_wr  <= ZERO;
        end else begin
            r_rcd <= i_act ? CW'(L_RCD) : sat_dec(r_rcd);
            r_ras <= i_act ? CW'(L_RAS) : sat_dec(r_ras);
            r_rc  <= i_act ? CW'(L_RC)  : sat_dec(r_rc);
            r_rp  <= i_pre ? CW'(L_RP)  : sat_dec(r_rp);
            r_wr  <= i_wr  ? CW'(L_WR)  : sat_dec(r_wr);
        end
    end

    assign o_active   = r_active;
    assign o_open_row = r_open_row;
    assign o_act_ok   = !r_active && (r_rp == ZERO) && (r_rc == ZERO);
    assign o_rw_ok    = r_active && (r_rcd == ZERO);
    assign o_pre_ok   = !r_active || ((r_ras == ZERO) && (r_wr == ZERO));
    assign o_pre_done = !r_active && (r_rp == ZERO);

endmodule

// File: rtl/sdram_bank_manager.sv
// Per-bank state/timing tracker and auto-refresh scheduler for an SDR SDRAM controller.
// Optional command-legality checker enabled by defining SDRAM_BANK_CHECK_EN.
module sdram_bank_manager
    import sdram_pkg::*;
#(
    parameter int NBANK        = 4,
    parameter int RAW          = 12,
    parameter int CLK_FREQ     = 100,
    parameter int tRAS         = 42,
    parameter int tRC          = 60,
    parameter int tRCD         = 18,
    parameter int tRP          = 18,
    parameter int tRRD         = 20,
    parameter int tRFC         = 60,
    parameter int tWR          = 15,
    parameter int cMRD         = 2,
    parameter int tREF         = 64,
    parameter int MAX_POSTPONE = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    input  logic [2:0]                        cmd_type,
    input  logic [$clog2(NBANK)-1:0]          cmd_ba,
    input  logic [RAW-1:0]                    cmd_row,
    input  logic [$clog2(NBANK)-1:0]          q_ba,
    input  logic [RAW-1:0]                    q_row,
    output logic [1:0]                        q_status,
    output logic                              q_act_ok,
    output logic                              q_rw_ok,
    output logic                              q_pre_ok,
    output logic                              all_idle,
    output logic                              ref_req,
    output logic                              ref_urgent,
    output logic [$clog2(MAX_POSTPONE+1)-1:0] ref_pending,
    output logic                              cmd_illegal
);

    localparam int BW     = $clog2(NBANK);
    localparam int PW     = $clog2(MAX_POSTPONE + 1);
    localparam int C_RCD  = ns2cyc(tRCD, CLK_FREQ);
    localparam int C_RAS  = ns2cyc(tRAS, CLK_FREQ);
    localparam int C_RC   = ns2cyc(tRC, CLK_FREQ);
    localparam int C_RP   = ns2cyc(tRP, CLK_FREQ);
    localparam int C_RRD  = ns2cyc(tRRD, CLK_FREQ);
    localparam int C_RFC  = ns2cyc(tRFC, CLK_FREQ);
    localparam int C_WR   = ns2cyc(tWR, CLK_FREQ);
    localparam int C_MRD  = (cMRD < 1) ? 1 : cMRD;
    localparam int C_REFI = refi_cyc(tREF, RAW, CLK_FREQ);
    localparam int CW     = $clog2(C_RC + C_RAS + C_RCD + C_RP + C_RRD + C_RFC + C_WR + C_MRD + 1);
    localparam int RW     = $clog2(C_REFI + 1);

    localparam logic [CW-1:0] ZERO   = {CW{1'b0}};
    localparam logic [RW-1:0] R_LOAD = RW'(C_REFI - 1);
    localparam logic [PW-1:0] P_MAX  = PW'(MAX_POSTPONE);
    localparam logic [PW-1:0] P_ZERO = {PW{1'b0}};

    sdram_cmd_e       w_cmd;
    logic             w_is_act;
    logic             w_is_wr;
    logic             w_is_pre;
    logic             w_is_prea;
    logic             w_is_ref;
    logic             w_is_mrs;
    logic [NBANK-1:0] w_active;
    logic [NBANK-1:0] w_bank_act_ok;
    logic [NBANK-1:0] w_bank_rw_ok;
    logic [NBANK-1:0] w_bank_pre_ok;
    logic [NBANK-1:0] w_bank_pre_done;
    logic [RAW-1:0]   w_open_row [NBANK];
    logic             w_glob_ok;
    logic             w_refi_exp;

    logic [CW-1:0]    r_rrd;
    logic [CW-1:0]    r_rfc;
    logic [CW-1:0]    r_mrd;
    logic [RW-1:0]    r_refi_cnt;
    logic [PW-1:0]    r_ref_pending;

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        return (v == ZERO) ? v : v - CW'(1);
    endfunction

    assign w_cmd = cmd_valid ? sdram_cmd_e'(cmd_type) : CMD_NOP;

    // One-hot command decode of the issued command.
    always_comb begin
        w_is_act  = 1'b0;
        w_is_wr   = 1'b0;
        w_is_pre  = 1'b0;
        w_is_prea = 1'b0;
        w_is_ref  = 1'b0;
        w_is_mrs  = 1'b0;
        case (w_cmd)
            CMD_ACT:  w_is_act  = 1'b1;
            CMD_WR:   w_is_wr   = 1'b1;
            CMD_PRE:  w_is_pre  = 1'b1;
            CMD_PREA: w_is_prea = 1'b1;
            CMD_REF:  w_is_ref  = 1'b1;
            CMD_MRS:  w_is_mrs  = 1'b1;
            default:  w_is_act  = 1'b0;
        endcase
    end

    for (genvar g = 0; g < NBANK; g++) begin : g_bank
        logic w_sel;
        assign w_sel = (cmd_ba == BW'(g));

        sdram_bank_timer #(
            .RAW   (RAW),
            .CW    (CW),
            .L_RCD (C_RCD - 1),
            .L_RAS (C_RAS - 1),
            .L_RC  (C_RC - 1),
            .L_RP  (C_RP - 1),
            .L_WR  (C_WR - 1)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .i_act      (w_is_act && w_sel),
            .i_wr       (w_is_wr && w_sel),
            .i_pre      ((w_is_pre && w_sel) || w_is_prea),
            .i_row      (cmd_row),
            .o_active   (w_active[g]),
            .o_open_row (w_open_row[g]),
            .o_act_ok   (w_bank_act_ok[g]),
            .o_rw_ok    (w_bank_rw_ok[g]),
            .o_pre_ok   (w_bank_pre_ok[g]),
            .o_pre_done (w_bank_pre_done[g])
        );
    end

    // Device-wide timers: ACT-to-ACT across banks, refresh recovery, mode-register delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rrd <= ZERO;
            r_rfc <= ZERO;
            r_mrd <= ZERO;
        end else begin
            r_rrd <= w_is_act ? CW'(C_RRD - 1) : sat_dec(r_rrd);
            r_rfc <= w_is_ref ? CW'(C_RFC - 1) : sat_dec(r_rfc);
            r_mrd <= w_is_mrs ? CW'(C_MRD - 1) : sat_dec(r_mrd);
        end
    end

    assign w_glob_ok = (r_rrd == ZERO) && (r_rfc == ZERO) && (r_mrd == ZERO);

    // Row-hit/miss classification for the queried bank.
    always_comb begin
        q_status = QS_CLOSED;
        if (!w_active[q_ba]) begin
            q_status = QS_CLOSED;
        end else if (w_open_row[q_ba] == q_row) begin
            q_status = QS_HIT;
        end else begin
            q_status = QS_CONFLICT;
        end
    end

    assign q_act_ok = w_bank_act_ok[q_ba] && w_glob_ok;
    assign q_rw_ok  = w_bank_rw_ok[q_ba];
    assign q_pre_ok = w_bank_pre_ok[q_ba];
    assign all_idle = (&w_bank_pre_done) && (r_rfc == ZERO) && (r_mrd == ZERO);

    assign w_refi_exp = (r_refi_cnt == {RW{1'b0}});

    // Free-running refresh interval timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refi_cnt <= R_LOAD;
        end else if (w_refi_exp) begin
            r_refi_cnt <= R_LOAD;
        end else begin
            r_refi_cnt <= r_refi_cnt - RW'(1);
        end
    end

    // Pending-refresh count; an expiry coinciding with REF cancels out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_pending <= P_ZERO;
        end else begin
            case ({w_refi_exp, w_is_ref})
                2'b10:   r_ref_pending <= (r_ref_pending == P_MAX) ? r_ref_pending
                                                                   : r_ref_pending + PW'(1);
                2'b01:   r_ref_pending <= (r_ref_pending == P_ZERO) ? r_ref_pending
                                                                    : r_ref_pending - PW'(1);
                default: r_ref_pending <= r_ref_pending;
            endcase
        end
    end

    assign ref_pending = r_ref_pending;
    assign ref_req     = (r_ref_pending != P_ZERO);
    assign ref_urgent  = (r_ref_pending == P_MAX);

`ifdef SDRAM_BANK_CHECK_EN
    logic w_illegal;
    logic r_cmd_illegal;

    // ACT to an open bank and RD/WR to a closed bank fail the ok terms, which include bank state.
    always_comb begin
        w_illegal = 1'b0;
        case (w_cmd)
            CMD_ACT:          w_illegal = !(w_bank_act_ok[cmd_ba] && w_glob_ok);
            CMD_RD, CMD_WR:   w_illegal = !w_bank_rw_ok[cmd_ba];
            CMD_PRE:          w_illegal = !w_bank_pre_ok[cmd_ba];
            CMD_REF, CMD_MRS: w_illegal = !all_idle;
            default:          w_illegal = 1'b0;
        endcase
    end

    // One-cycle violation flag for the previous command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_illegal <= 1'b0;
        end else begin
            r_cmd_illegal <= w_illegal;
        end
    end

    assign cmd_illegal = r_cmd_illegal;
`else
    assign cmd_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_bank_manager.sv
// Randomised self-checking bench for sdram_bank_manager against a timestamp-based reference model.
module tb_sdram_bank_manager;

    localparam int NB   = 4;
    localparam int RCD  = 2;
    localparam int RAS  = 5;
    localparam int RC   = 6;
    localparam int RP   = 2;
    localparam int RRD  = 2;
    localparam int RFC  = 6;
    localparam int WRC  = 2;
    localparam int MRD  = 2;
    localparam int REFI = 1562;
    localparam int MAXP = 8;

    localparam logic [2:0] K_NOP  = 3'd0;
    localparam logic [2:0] K_ACT  = 3'd1;
    localparam logic [2:0] K_RD   = 3'd2;
    localparam logic [2:0] K_WR   = 3'd3;
    localparam logic [2:0] K_PRE  = 3'd4;
    localparam logic [2:0] K_PREA = 3'd5;
    localparam logic [2:0] K_REF  = 3'd6;
    localparam logic [2:0] K_MRS  = 3'd7;

`ifdef SDRAM_BANK_CHECK_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [1:0]  cmd_ba;
    logic [11:0] cmd_row;
    logic [1:0]  q_ba;
    logic [11:0] q_row;
    logic [1:0]  q_status;
    logic        q_act_ok;
    logic        q_rw_ok;
    logic        q_pre_ok;
    logic        all_idle;
    logic        ref_req;
    logic        ref_urgent;
    logic [3:0]  ref_pending;
    logic        cmd_illegal;

    int n_checks;
    int n_errors;

    // reference model: bank state plus the first cycle at which each gated command is legal
    bit          m_active [NB];
    logic [11:0] m_row    [NB];
    longint      t_rw [NB], t_ras [NB], t_rc [NB], t_rp [NB], t_wr [NB];
    longint      t_rrd, t_rfc, t_mrd;
    longint      cyc;
    int          pend;
    bit          exp_ill;

    sdram_bank_manager dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_type    (cmd_type),
        .cmd_ba      (cmd_ba),
        .cmd_row     (cmd_row),
        .q_ba        (q_ba),
        .q_row       (q_row),
        .q_status    (q_status),
        .q_act_ok    (q_act_ok),
        .q_rw_ok     (q_rw_ok),
        .q_pre_ok    (q_pre_ok),
        .all_idle    (all_idle),
        .ref_req     (ref_req),
        .ref_urgent  (ref_urgent),
        .ref_pending (ref_pending),
        .cmd_illegal (cmd_illegal)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit e_act_ok(input int b);
        return !m_active[b] && cyc >= t_rp[b] && cyc >= t_rc[b] &&
               cyc >= t_rrd && cyc >= t_rfc && cyc >= t_mrd;
    endfunction

    function automatic bit e_rw_ok(input int b);
        return m_active[b] && cyc >= t_rw[b];
    endfunction

    function automatic bit e_pre_ok(input int b);
        return !m_active[b] || (cyc >= t_ras[b] && cyc >= t_wr[b]);
    endfunction

    function automatic bit e_all_idle();
        bit ok;
        ok = (cyc >= t_rfc) && (cyc >= t_mrd);
        for (int b = 0; b < NB; b++) ok = ok && !m_active[b] && (cyc >= t_rp[b]);
        return ok;
    endfunction

    function automatic logic [1:0] e_status(input int b, input logic [11:0] r);
        if (!m_active[b]) return 2'd0;
        return (m_row[b] == r) ? 2'd1 : 2'd2;
    endfunction

`ifdef SDRAM_BANK_CHECK_EN
    function automatic bit e_illegal(input logic [2:0] t, input int b);
        case (t)
            K_ACT:        return !e_act_ok(b);
            K_RD, K_WR:   return !e_rw_ok(b);
            K_PRE:        return !e_pre_ok(b);
            K_REF, K_MRS: return !e_all_idle();
            default:      return 1'b0;
        endcase
    endfunction
`endif

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_active[b] = 1'b0; m_row[b] = 12'd0;
            t_rw[b] = 0; t_ras[b] = 0; t_rc[b] = 0; t_rp[b] = 0; t_wr[b] = 0;
        end
        t_rrd = 0; t_rfc = 0; t_mrd = 0;
        cyc = 0; pend = 0; exp_ill = 1'b0;
    endtask

    task automatic model_cmd(input bit v, input logic [2:0] t, input int b, input logic [11:0] row);
        bit expiry;
        bit refr;
`ifdef SDRAM_BANK_CHECK_EN
        exp_ill = v && e_illegal(t, b);
`else
        exp_ill = 1'b0;
`endif
        if (v) begin
            case (t)
                K_ACT: begin
                    m_active[b] = 1'b1; m_row[b] = row;
                    t_rw[b] = cyc + RCD; t_ras[b] = cyc + RAS; t_rc[b] = cyc + RC; t_rrd = cyc + RRD;
                end
                K_WR:   t_wr[b] = cyc + WRC;
                K_PRE:  begin m_active[b] = 1'b0; t_rp[b] = cyc + RP; end
                K_PREA: for (int i = 0; i < NB; i++) begin m_active[i] = 1'b0; t_rp[i] = cyc + RP; end
                K_REF:  t_rfc = cyc + RFC;
                K_MRS:  t_mrd = cyc + MRD;
                default: ;
            endcase
        end
        expiry = (cyc % REFI) == REFI - 1;
        refr   = v && (t == K_REF);
        if (expiry && !refr) pend = (pend < MAXP) ? pend + 1 : pend;
        else if (refr && !expiry) pend = (pend > 0) ? pend - 1 : 0;
        cyc++;
    endtask

    task automatic check_outputs(input int qb, input logic [11:0] qr);
        check_val("q_status",    q_status,    e_status(qb, qr));
        check_val("q_act_ok",    q_act_ok,    e_act_ok(qb));
        check_val("q_rw_ok",     q_rw_ok,     e_rw_ok(qb));
        check_val("q_pre_ok",    q_pre_ok,    e_pre_ok(qb));
        check_val("all_idle",    all_idle,    e_all_idle());
        check_val("ref_pending", ref_pending, pend);
        check_val("ref_req",     ref_req,     pend != 0);
        check_val("ref_urgent",  ref_urgent,  pend == MAXP);
        check_val("cmd_illegal", cmd_illegal, exp_ill);
    endtask

    // called just after a falling edge: drive, check, advance model, wait for next falling edge
    task automatic step(input bit v, input logic [2:0] t, input int b, input logic [11:0] row,
                        input int qb, input logic [11:0] qr);
        cmd_valid = v; cmd_type = t; cmd_ba = 2'(b); cmd_row = row;
        q_ba = 2'(qb); q_row = qr;
        #1;
        check_outputs(qb, qr);
        model_cmd(v, t, b, row);
        @(negedge clk);
    endtask

    task automatic nops(input int n, input int qb);
        for (int i = 0; i < n; i++) step(1'b0, K_NOP, 0, 12'd0, qb, m_row[qb]);
    endtask

    task automatic peek(input int qb, input logic [11:0] qr);
        cmd_valid = 1'b0; q_ba = 2'(qb); q_row = qr;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_type = K_NOP; cmd_ba = 2'd0; cmd_row = 12'd0;
        q_ba = 2'd0; q_row = 12'd0;
        #1;
        model_reset();
        check_outputs(0, 12'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int qb;
        logic [11:0] qr;
        n_checks = 0;
        n_errors = 0;
        do_reset();

        step(1'b1, K_RD, 2, 12'd0, 2, 12'd0);
        peek(2, 12'd0);
        check_val("ill_rd_idle", cmd_illegal, EXP_ILL);
        nops(1, 1);

        // ACT bank1 row 0x123: tRCD and tRAS windows, hit/conflict
        step(1'b1, K_ACT, 1, 12'h123, 1, 12'h123);
        peek(1, 12'h123);
        check_val("rcd_t1", q_rw_ok, 1'b0);
        check_val("hit", q_status, 2'd1);
        peek(1, 12'h124);
        check_val("conflict", q_status, 2'd2);
        nops(1, 1);
        peek(1, 12'h123);
        check_val("rcd_t2", q_rw_ok, 1'b1);
        nops(2, 1);
        peek(1, 12'h123);
        check_val("ras_t4", q_pre_ok, 1'b0);
        nops(1, 1);
        peek(1, 12'h123);
        check_val("ras_t5", q_pre_ok, 1'b1);

        // ACT bank0, tRRD seen on bank2; PRE bank0 then tRP
        step(1'b1, K_ACT, 0, 12'h005, 2, 12'd0);
        peek(2, 12'd0);
        check_val("rrd_t1", q_act_ok, 1'b0);
        nops(1, 2);
        peek(2, 12'd0);
        check_val("rrd_t2", q_act_ok, 1'b1);
        nops(3, 0);
        step(1'b1, K_PRE, 0, 12'd0, 0, 12'd0);
        peek(0, 12'd0);
        check_val("rp_t6", q_act_ok, 1'b0);
        nops(1, 0);
        peek(0, 12'd0);
        check_val("rp_t7", q_act_ok, 1'b1);

        // WR bank3 then tWR before PRE
        step(1'b1, K_ACT, 3, 12'h0AB, 3, 12'h0AB);
        nops(3, 3);
        step(1'b1, K_WR, 3, 12'd0, 3, 12'h0AB);
        peek(3, 12'h0AB);
        check_val("wr_t1", q_pre_ok, 1'b0);
        nops(1, 3);
        peek(3, 12'h0AB);
        check_val("wr_t2", q_pre_ok, 1'b1);

        // ACT one cycle after PRE on the same bank
        step(1'b1, K_PRE, 3, 12'd0, 3, 12'd0);
        step(1'b1, K_ACT, 3, 12'h001, 3, 12'h001);
        peek(3, 12'h001);
        check_val("ill_act_after_pre", cmd_illegal, EXP_ILL);

        // PREA then REF: all_idle held off by tRFC
        step(1'b1, K_PREA, 0, 12'd0, 0, 12'd0);
        step(1'b1, K_REF, 0, 12'd0, 0, 12'd0);
        peek(0, 12'd0);
        check_val("rfc_t1", all_idle, 1'b0);
        nops(4, 0);
        peek(0, 12'd0);
        check_val("rfc_t5", all_idle, 1'b0);
        nops(1, 0);
        peek(0, 12'd0);
        check_val("rfc_t6", all_idle, 1'b1);

        // random traffic spanning a couple of refresh intervals
        for (int i = 0; i < 3400; i++) begin
            qb = $urandom_range(0, NB - 1);
            qr = ($urandom_range(0, 1) == 0) ? m_row[qb] : 12'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, NB - 1),
                 12'($urandom_range(0, 3)), qb, qr);
        end

        do_reset();

        // refresh postponement saturation
        while (cyc < REFI * MAXP + 5) nops(1, $urandom_range(0, NB - 1));
        peek(0, 12'd0);
        check_val("sat_pending", ref_pending, 4'd8);
        check_val("sat_urgent", ref_urgent, 1'b1);
        while ((cyc % REFI) != REFI - 1) nops(1, 0);
        step(1'b1, K_REF, 0, 12'd0, 0, 12'd0);
        peek(0, 12'd0);
        check_val("ref_on_expiry", ref_pending, 4'd8);
        nops(RFC, 0);
        step(1'b1, K_REF, 0, 12'd0, 0, 12'd0);
        peek(0, 12'd0);
        check_val("ref_dec", ref_pending, 4'd7);
        check_val("ref_dec_urgent", ref_urgent, 1'b0);
        nops(2, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
